rhd_spi_engine: RTL and testbench

RHD_SPI_ENGINE -- requirements
Module: rhd_spi_engine

---
 rtl/rhd_spi_engine.sv | 164 ++++++++++++++++
 tb/tb_rhd_spi_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd_spi_engine.sv
// SPI frame engine for RHD headstages: one 16-bit command word per MOSI lane,
// per-MISO delay-compensated capture on SCLK rising (and optionally falling) edges.
module rhd_spi_engine #(
  parameter int NUM_MOSI    = 2,
  parameter int NUM_MISO    = 4,
  parameter int CLK_DIV     = 4,
  parameter int CS_HIGH_CYC = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [NUM_MOSI*16-1:0]  cmd_data,
  input  logic [NUM_MISO*4-1:0]   delay,
  input  logic                    ddr_en,
  input  logic [NUM_MISO-1:0]     MISO,
  output logic                    CS,
  output logic                    SCLK,
  output logic [NUM_MOSI-1:0]     MOSI,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NUM_MISO*32-1:0]  res_data,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int H     = CLK_DIV / 2;
  localparam int T_CYC = (CS_HIGH_CYC > 15 + CLK_DIV) ? CS_HIGH_CYC : 15 + CLK_DIV;
  localparam int PW    = $clog2(CLK_DIV);
  localparam int TW    = $clog2(T_CYC);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_H    = PW'(H);
  localparam logic [TW-1:0] T_LAST  = TW'(T_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, DONE} state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          ph;
  logic [3:0]             bit_idx;
  logic [TW-1:0]          tail_cnt;
  logic [15:0]            tx_sh   [NUM_MOSI];
  logic [3:0]             delay_q [NUM_MISO];
  logic                   ddr_q;
  logic [14:0]            rise_hist, fall_hist;
  logic [15:0]            rise_all, fall_all;
  logic                   rise_nom, fall_nom;
  logic [15:0]            rise_sh [NUM_MISO];
  logic [15:0]            fall_sh [NUM_MISO];
  logic [NUM_MISO*32-1:0] cap_word, res_data_r;
  logic                   res_valid_r;
  logic                   accept, shift_last;

  // Both handshakes are strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; a presented result holds valid and data until taken.
  assign accept     = cmd_valid && cmd_ready;
  assign shift_last = (ph == PH_LAST) && (bit_idx == 4'd15);

  assign cmd_ready = (state == IDLE) && !areset;
  assign busy      = (state != IDLE);
  assign CS        = (state != SHIFT);
  assign SCLK      = (state == SHIFT) && (ph >= PH_H);
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign dbg_state = state;

  always_comb begin
    for (int i = 0; i < NUM_MOSI; i++) MOSI[i] = tx_sh[i][15];
  end

  // Nominal sample strobes; the final falling sample lands on the first TAIL cycle.
  assign rise_nom = (state == SHIFT) && (ph == PH_H);
  assign fall_nom = ((state == SHIFT) && (ph == '0) && (bit_idx != 4'd0)) ||
                    ((state == TAIL) && (tail_cnt == '0));
  assign rise_all = {rise_hist, rise_nom};
  assign fall_all = {fall_hist, fall_nom};

  always_comb begin
    cap_word = '0;
    for (int m = 0; m < NUM_MISO; m++) begin
      cap_word[32*m +: 16]    = rise_sh[m];
      cap_word[32*m+16 +: 16] = fall_sh[m];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (shift_last) state_nxt = TAIL;
      TAIL:    if (tail_cnt == T_LAST) state_nxt = DONE;
      DONE:    if (res_valid_r && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      ph          <= '0;
      bit_idx     <= '0;
      tail_cnt    <= '0;
      ddr_q       <= 1'b0;
      rise_hist   <= '0;
      fall_hist   <= '0;
      res_data_r  <= '0;
      res_valid_r <= 1'b0;
      for (int i = 0; i < NUM_MOSI; i++) tx_sh[i] <= '0;
      for (int m = 0; m < NUM_MISO; m++) begin
        delay_q[m] <= '0;
        rise_sh[m] <= '0;
        fall_sh[m] <= '0;
      end
    end else begin
      state     <= state_nxt;
      rise_hist <= {rise_hist[13:0], rise_nom};
      fall_hist <= {fall_hist[13:0], fall_nom};
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < NUM_MOSI; i++) tx_sh[i] <= cmd_data[16*i +: 16];
            for (int m = 0; m < NUM_MISO; m++) delay_q[m] <= delay[4*m +: 4];
            ddr_q   <= ddr_en;
            ph      <= '0;
            bit_idx <= '0;
          end
        end
        SHIFT: begin
          tail_cnt <= '0;
          if (ph == PH_LAST) begin
            ph <= '0;
            // The last bit is not shifted out so MOSI rests on it between frames.
            if (bit_idx != 4'd15) begin
              bit_idx <= bit_idx + 4'd1;
              for (int i = 0; i < NUM_MOSI; i++) tx_sh[i] <= {tx_sh[i][14:0], 1'b0};
            end
          end else begin
            ph <= ph + PW'(1);
          end
        end
        TAIL: tail_cnt <= tail_cnt + TW'(1);
        DONE: begin
          // First DONE cycle moves the capture words into the output register.
          if (!res_valid_r) begin
            res_valid_r <= 1'b1;
            res_data_r  <= cap_word;
          end else if (res_ready) begin
            res_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
      for (int m = 0; m < NUM_MISO; m++) begin
        if ((state == IDLE) && accept) begin
          rise_sh[m] <= '0;
          fall_sh[m] <= '0;
        end else if ((state == SHIFT) || (state == TAIL)) begin
          if (rise_all[delay_q[m]]) rise_sh[m] <= {rise_sh[m][14:0], MISO[m]};
          if (ddr_q && fall_all[delay_q[m]]) fall_sh[m] <= {fall_sh[m][14:0], MISO[m]};
        end
      end
    end
  end

endmodule

// File: tb/tb_rhd_spi_engine.sv
// Directed bench for rhd_spi_engine: loopback/delayed/DDR MISO models, stall,
// mid-frame reset and mid-frame delay change.
module tb_rhd_spi_engine;

  localparam int CS_HIGH_CYC = 4;
  localparam logic [15:0] W1 = 16'h1234;
  localparam logic [15:0] W2 = 16'hFEDC;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_data = '0;
  logic [15:0]  delay = '0;
  logic         ddr_en = 1'b0;
  logic [3:0]   MISO;
  logic         CS, SCLK;
  logic [1:0]   MOSI;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // MISO models: 0 = MOSI[0] delayed by tb_dly[m] cycles, 1 = DDR word model
  int          miso_mode = 0;
  int          tb_dly [4] = '{0, 0, 0, 0};
  logic [14:0] hist = '0;
  int          frame_cyc = 0;

  logic [127:0] fr_data;
  int           fr_lat, fr_sclk, fr_cs_bad;
  logic [15:0]  fr_mosi0, fr_mosi1;
  int           mid_mode = 0;
  logic [31:0]  mid_cmd = '0;
  logic [15:0]  mid_delay = '0;

  rhd_spi_engine dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .delay(delay), .ddr_en(ddr_en), .MISO(MISO),
    .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  always @(posedge aclk) begin
    hist <= {hist[13:0], MOSI[0]};
    if (cmd_valid && cmd_ready) frame_cyc <= 1;
    else frame_cyc <= frame_cyc + 1;
  end

  // Cycle n of a frame: rising sample of bit k at phase 2, falling sample of bit k at phase 0 of bit k+1.
  function automatic logic ddr_bit(input int n, input logic [15:0] w1, input logic [15:0] w2);
    int p, k;
    if (n < 1) return 1'b0;
    p = (n - 1) % 4;
    k = (n - 1) / 4;
    if (p == 0 && k >= 1 && k <= 16) return w2[16-k];
    if (k <= 15) return w1[15-k];
    return 1'b0;
  endfunction

  always_comb begin
    MISO = '0;
    for (int m = 0; m < 4; m++) begin
      if (miso_mode == 1) MISO[m] = ddr_bit(frame_cyc, W1, W2);
      else if (tb_dly[m] == 0) MISO[m] = MOSI[0];
      else MISO[m] = hist[tb_dly[m]-1];
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] cmd);
    int guard;
    guard = 0;
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 300) begin
      @(posedge aclk); #1;
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL send_ready: cmd_ready got %b expected 1 within 300 cycles", cmd_ready);
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  // Called on cycle 1 of a frame; returns once the result is taken.
  task automatic observe_frame();
    logic prev;
    prev = 1'b0;
    fr_lat = -1; fr_sclk = 0; fr_cs_bad = 0;
    fr_mosi0 = '0; fr_mosi1 = '0; fr_data = '0;
    for (int n = 1; n <= 200; n++) begin
      if (SCLK === 1'b1 && prev === 1'b0) fr_sclk++;
      prev = SCLK;
      if (n <= 64 && CS !== 1'b0) fr_cs_bad++;
      if (n == 65 && CS !== 1'b1) fr_cs_bad++;
      if (n <= 64 && ((n - 1) % 4) == 2) begin
        fr_mosi0[15-(n-1)/4] = MOSI[0];
        fr_mosi1[15-(n-1)/4] = MOSI[1];
      end
      if (n == 20 && mid_mode == 1) begin
        delay    = mid_delay;
        cmd_data = mid_cmd;
      end
      if (res_valid === 1'b1) begin
        fr_lat  = n;
        fr_data = res_data;
        res_ready = 1'b1;
        @(posedge aclk); #1;
        res_ready = 1'b0;
        break;
      end
      @(posedge aclk); #1;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (CS !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", CS); end
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", SCLK); end
    checks++; if (MOSI !== 2'b00) begin errors++; $display("FAIL reset_mosi: got %b expected 00", MOSI); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (res_data !== 128'h0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
    areset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_basic();
    miso_mode = 0; tb_dly = '{0, 0, 0, 0}; delay = '0; ddr_en = 1'b0;
    send({16'h0F5A, 16'hA5C3});
    observe_frame();
    checks++; if (fr_mosi0 !== 16'hA5C3) begin errors++; $display("FAIL basic_mosi0: got %h expected a5c3", fr_mosi0); end
    checks++; if (fr_mosi1 !== 16'h0F5A) begin errors++; $display("FAIL basic_mosi1: got %h expected 0f5a", fr_mosi1); end
    checks++; if (fr_sclk != 16) begin errors++; $display("FAIL basic_sclk_pulses: got %0d expected 16", fr_sclk); end
    checks++; if (fr_cs_bad != 0) begin errors++; $display("FAIL basic_cs_window: got %0d bad cycles expected 0", fr_cs_bad); end
    checks++; if (fr_lat != 85) begin errors++; $display("FAIL basic_latency: got %0d expected 85", fr_lat); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fr_data[32*m +: 32] !== 32'h0000_A5C3) begin
        errors++; $display("FAIL basic_word%0d: got %h expected 0000a5c3", m, fr_data[32*m +: 32]);
      end
    end
    checks++; if (MOSI !== 2'b01) begin errors++; $display("FAIL basic_mosi_hold: got %b expected 01", MOSI); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL basic_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, cmd_ready);
    end
  endtask

  task automatic test_delay();
    miso_mode = 0; tb_dly = '{0, 3, 7, 15};
    delay = {4'd15, 4'd7, 4'd3, 4'd0};
    send(32'h0000_3C96);
    observe_frame();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fr_data[32*m +: 32] !== 32'h0000_3C96) begin
        errors++; $display("FAIL delay_word%0d: got %h expected 00003c96", m, fr_data[32*m +: 32]);
      end
    end
    checks++; if (fr_lat != 85) begin errors++; $display("FAIL delay_latency: got %0d expected 85", fr_lat); end
  endtask

  task automatic test_ddr();
    miso_mode = 1; delay = '0; ddr_en = 1'b1;
    send(32'h0000_5555);
    observe_frame();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fr_data[32*m +: 32] !== {W2, W1}) begin
        errors++; $display("FAIL ddr_word%0d: got %h expected fedc1234", m, fr_data[32*m +: 32]);
      end
    end
    ddr_en = 1'b0; miso_mode = 0;
  endtask

  task automatic test_stall();
    logic [127:0] snap;
    int n, cs_run, bad_stable, bad_ready, cs_fall;
    miso_mode = 0; tb_dly = '{0, 0, 0, 0}; delay = '0;
    send(32'h0000_C3A5);
    cmd_valid = 1'b1; cmd_data = 32'h0000_7E81;
    n = 1; cs_run = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      if (CS === 1'b1) cs_run++; else cs_run = 0;
      @(posedge aclk); #1;
      n++;
    end
    checks++; if (n != 85) begin errors++; $display("FAIL stall_latency: got %0d expected 85", n); end
    snap = res_data;
    checks++; if (snap[31:0] !== 32'h0000_C3A5) begin errors++; $display("FAIL stall_word0: got %h expected 0000c3a5", snap[31:0]); end
    bad_stable = 0; bad_ready = 0; cs_fall = 0;
    for (int i = 0; i < 50; i++) begin
      cs_run++;
      @(posedge aclk); #1;
      if (res_data !== snap || res_valid !== 1'b1) bad_stable++;
      if (cmd_ready !== 1'b0) bad_ready++;
      if (CS !== 1'b1) cs_fall++;
    end
    checks++; if (bad_stable != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad_stable); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL stall_cmd_ready: got %0d ready cycles expected 0", bad_ready); end
    checks++; if (cs_fall != 0) begin errors++; $display("FAIL stall_cs: got %0d low cycles expected 0", cs_fall); end
    res_ready = 1'b1;
    cs_run++;
    @(posedge aclk); #1;
    res_ready = 1'b0;
    n = 0;
    while (CS === 1'b1 && n < 20) begin
      cs_run++;
      @(posedge aclk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    checks++; if (cs_run < CS_HIGH_CYC) begin errors++; $display("FAIL stall_cs_high: got %0d expected >= %0d", cs_run, CS_HIGH_CYC); end
    observe_frame();
    checks++; if (fr_data[31:0] !== 32'h0000_7E81) begin errors++; $display("FAIL stall_next_word0: got %h expected 00007e81", fr_data[31:0]); end
    checks++; if (fr_lat != 85) begin errors++; $display("FAIL stall_next_latency: got %0d expected 85", fr_lat); end
  endtask

  task automatic test_reset_abort();
    logic prev;
    int rises, seen_valid;
    miso_mode = 0; tb_dly = '{0, 0, 0, 0}; delay = '0;
    send(32'h0000_ABCD);
    prev = 1'b0; rises = 0;
    for (int n = 1; n <= 64; n++) begin
      if (SCLK === 1'b1 && prev === 1'b0) rises++;
      prev = SCLK;
      if (rises == 8) break;
      @(posedge aclk); #1;
    end
    checks++; if (rises != 8) begin errors++; $display("FAIL abort_pulse8: got %0d pulses expected 8", rises); end
    areset = 1'b1;
    @(posedge aclk); #1;
    checks++; if (CS !== 1'b1) begin errors++; $display("FAIL abort_cs: got %b expected 1", CS); end
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_state: got busy=%b valid=%b expected 0 0", busy, res_valid);
    end
    checks++; if (res_data !== 128'h0) begin errors++; $display("FAIL abort_res_data: got %h expected 0", res_data); end
    areset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", cmd_ready); end
    seen_valid = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge aclk); #1;
      if (res_valid === 1'b1) seen_valid++;
    end
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen_valid); end
    send(32'h0000_6C39);
    observe_frame();
    checks++; if (fr_data[127:96] !== 32'h0000_6C39) begin errors++; $display("FAIL abort_next_word3: got %h expected 00006c39", fr_data[127:96]); end
    checks++; if (fr_lat != 85) begin errors++; $display("FAIL abort_next_latency: got %0d expected 85", fr_lat); end
  endtask

  task automatic test_delay_change();
    miso_mode = 0; tb_dly = '{0, 0, 0, 0}; delay = '0;
    mid_mode = 1; mid_delay = 16'hFFFF; mid_cmd = 32'h0;
    send(32'h0000_9B2D);
    observe_frame();
    mid_mode = 0;
    checks++; if (fr_mosi0 !== 16'h9B2D) begin errors++; $display("FAIL dchg_mosi: got %h expected 9b2d", fr_mosi0); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fr_data[32*m +: 16] !== 16'h9B2D) begin
        errors++; $display("FAIL dchg_first_word%0d: got %h expected 9b2d", m, fr_data[32*m +: 16]);
      end
    end
    tb_dly = '{15, 15, 15, 15};
    send(32'h0000_4E71);
    observe_frame();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fr_data[32*m +: 16] !== 16'h4E71) begin
        errors++; $display("FAIL dchg_second_word%0d: got %h expected 4e71", m, fr_data[32*m +: 16]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_ddr();
    test_stall();
    test_reset_abort();
    test_delay_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
